// File: rtl/pipe_stage_fifo.sv
// Elastic valid/ready buffer between pipeline stages: DEPTH-entry circular store with an
// optional fall-through path that forwards a beat in the same cycle when the buffer is empty.
module pipe_stage_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned FLOW  = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [WIDTH-1:0]         s_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [WIDTH-1:0]         m_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW-1:0] CountFull = CntW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CntW-1:0]  count_q, count_d;

   logic active;
   logic empty;
   logic full;
   logic bypass_sel;
   logic push;
   logic pop;
   logic store;
   logic pop_mem;

   assign active = !rst && !flush;
   assign empty  = (count_q == '0);
   assign full   = (count_q == CountFull);

   // Fall-through path is only selected while nothing is stored.
   assign bypass_sel = (FLOW != 0) && empty;

   always_comb begin
      s_ready = active && !full;
      if (bypass_sel) begin
         m_valid = s_valid && active;
         m_data  = s_data;
      end else begin
         m_valid = active && !empty;
         m_data  = mem_q[rd_ptr_q];
      end
   end

   assign push = s_valid && s_ready;
   assign pop  = m_valid && m_ready;

   // A bypassed beat is both pushed and popped but never touches storage.
   assign store   = push && !(bypass_sel && m_ready);
   assign pop_mem = pop && !bypass_sel;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (store) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (pop_mem) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         unique case ({store, pop_mem})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         if (store && !flush) begin
            mem_q[wr_ptr_q] <= s_data;
         end
      end
   end

   assign count = count_q;

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Drives one shared stimulus stream into three buffer configurations and checks each against
// a queue model every cycle, plus literal expectations at the points of interest.
module tb_pipe_stage_fifo;

   logic clk;
   logic rst;
   logic flush;
   logic s_valid;
   logic [7:0] s_data;
   logic m_ready;

   logic [2:0]      s_ready_w;
   logic [2:0]      m_valid_w;
   logic [2:0][7:0] m_data_w;
   logic [2:0][2:0] count_w;

   int checks;
   int failures;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Instance 0: FLOW=0 DEPTH=2, instance 1: FLOW=0 DEPTH=4, instance 2: FLOW=1 DEPTH=2.
   for (genvar g = 0; g < 3; g++) begin : gen_dut
      localparam int unsigned D = (g == 1) ? 4 : 2;
      localparam int unsigned F = (g == 2) ? 1 : 0;

      logic [$clog2(D):0] cnt;
      logic [7:0] mq[$];

      pipe_stage_fifo #(
         .WIDTH (8),
         .DEPTH (D),
         .FLOW  (F)
      ) u_dut (
         .clk     (clk),
         .rst     (rst),
         .flush   (flush),
         .s_valid (s_valid),
         .s_ready (s_ready_w[g]),
         .s_data  (s_data),
         .m_valid (m_valid_w[g]),
         .m_ready (m_ready),
         .m_data  (m_data_w[g]),
         .count   (cnt)
      );

      assign count_w[g] = 3'(cnt);

      always @(posedge clk) begin
         int unsigned n;
         bit act, sr, byp, mv;
         n   = mq.size();
         act = !rst && !flush;
         sr  = act && (n < D);
         byp = (F == 1) && (n == 0);
         mv  = byp ? (s_valid && act) : (act && n > 0);
         if (!act) begin
            mq.delete();
         end else if (byp && s_valid && m_ready) begin
            n = 0;
         end else begin
            if (mv && m_ready) void'(mq.pop_front());
            if (s_valid && sr) mq.push_back(s_data);
         end
      end

      always @(negedge clk) begin
         int unsigned n;
         bit act, sr, byp, mv;
         logic [7:0] md;
         n   = mq.size();
         act = !rst && !flush;
         sr  = act && (n < D);
         byp = (F == 1) && (n == 0);
         mv  = byp ? (s_valid && act) : (act && n > 0);
         md  = byp ? s_data : ((n > 0) ? mq[0] : 8'h00);
         chk($sformatf("i%0d s_ready", g), 32'(s_ready_w[g]), 32'(sr));
         chk($sformatf("i%0d m_valid", g), 32'(m_valid_w[g]), 32'(mv));
         chk($sformatf("i%0d count", g), 32'(count_w[g]), 32'(n));
         if (mv) chk($sformatf("i%0d m_data", g), 32'(m_data_w[g]), 32'(md));
      end
   end

   task automatic step(input logic r, input logic f, input logic sv, input logic [7:0] d,
                       input logic mr);
      @(posedge clk);
      #1;
      rst     = r;
      flush   = f;
      s_valid = sv;
      s_data  = d;
      m_ready = mr;
      @(negedge clk);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      flush    = 1'b0;
      s_valid  = 1'b0;
      s_data   = 8'h00;
      m_ready  = 1'b0;

      // Reset and idle
      step(1, 0, 0, 8'h00, 0);
      chk("rst s_ready", 32'(s_ready_w[0]), 32'd0);
      chk("rst m_valid", 32'(m_valid_w[0]), 32'd0);
      step(1, 0, 0, 8'h00, 0);
      step(0, 0, 0, 8'h00, 0);
      chk("idle s_ready", 32'(s_ready_w[0]), 32'd1);
      chk("idle m_valid", 32'(m_valid_w[0]), 32'd0);
      chk("idle count", 32'(count_w[0]), 32'd0);
      chk("idle m_data0", 32'(m_data_w[0]), 32'd0);
      chk("idle m_data1", 32'(m_data_w[1]), 32'd0);

      // Streaming at full rate
      step(0, 0, 1, 8'h11, 1);
      chk("stream first bubble", 32'(m_valid_w[0]), 32'd0);
      step(0, 0, 1, 8'h22, 1);
      chk("stream d0", 32'(m_data_w[0]), 32'h11);
      chk("stream c0", 32'(count_w[0]), 32'd1);
      step(0, 0, 1, 8'h33, 1);
      chk("stream d1", 32'(m_data_w[0]), 32'h22);
      chk("stream v1", 32'(m_valid_w[0]), 32'd1);
      step(0, 0, 0, 8'h00, 1);
      chk("stream d2", 32'(m_data_w[0]), 32'h33);
      chk("stream c2", 32'(count_w[0]), 32'd1);
      step(0, 0, 0, 8'h00, 1);

      // Backpressure until full, then drain with wrap
      for (int i = 0; i < 4; i++) step(0, 0, 1, 8'(8'hA0 + i), 0);
      step(0, 0, 1, 8'hA4, 0);
      chk("full count", 32'(count_w[1]), 32'd4);
      chk("full s_ready", 32'(s_ready_w[1]), 32'd0);
      step(0, 0, 1, 8'hA4, 0);
      chk("full hold d", 32'(m_data_w[1]), 32'hA0);
      step(0, 0, 1, 8'hA4, 1);
      chk("drain A0", 32'(m_data_w[1]), 32'hA0);
      chk("full pop s_ready", 32'(s_ready_w[1]), 32'd0);
      chk("d2 full count", 32'(count_w[0]), 32'd2);
      chk("d2 full s_ready", 32'(s_ready_w[0]), 32'd0);
      step(0, 0, 1, 8'hA4, 1);
      chk("drain A1", 32'(m_data_w[1]), 32'hA1);
      chk("d2 after pop count", 32'(count_w[0]), 32'd1);
      chk("d2 after pop s_ready", 32'(s_ready_w[0]), 32'd1);
      step(0, 0, 1, 8'hA5, 1);
      chk("drain A2", 32'(m_data_w[1]), 32'hA2);
      step(0, 0, 0, 8'h00, 1);
      chk("drain A3", 32'(m_data_w[1]), 32'hA3);
      step(0, 0, 0, 8'h00, 1);
      chk("drain A4", 32'(m_data_w[1]), 32'hA4);
      step(0, 0, 0, 8'h00, 1);
      chk("drain A5", 32'(m_data_w[1]), 32'hA5);
      step(0, 0, 0, 8'h00, 1);
      chk("drain empty", 32'(m_valid_w[1]), 32'd0);
      step(0, 0, 0, 8'h00, 1);
      step(0, 0, 0, 8'h00, 1);

      // Flush discards stored entries and the concurrent beat
      step(0, 0, 1, 8'hB1, 0);
      step(0, 0, 1, 8'hB2, 0);
      step(0, 0, 1, 8'hB3, 0);
      step(0, 1, 1, 8'hFF, 1);
      chk("flush m_valid", 32'(m_valid_w[1]), 32'd0);
      chk("flush s_ready", 32'(s_ready_w[1]), 32'd0);
      chk("flush count before", 32'(count_w[1]), 32'd3);
      step(0, 0, 0, 8'h00, 1);
      chk("flush count after", 32'(count_w[1]), 32'd0);
      chk("flush m_valid after", 32'(m_valid_w[1]), 32'd0);
      step(0, 0, 0, 8'h00, 1);

      // Fall-through bypass and stored fall-through beat
      step(0, 0, 1, 8'h5A, 1);
      chk("ft bypass v", 32'(m_valid_w[2]), 32'd1);
      chk("ft bypass d", 32'(m_data_w[2]), 32'h5A);
      chk("ft bypass c", 32'(count_w[2]), 32'd0);
      step(0, 0, 0, 8'h00, 0);
      chk("ft bypass c next", 32'(count_w[2]), 32'd0);
      step(0, 0, 1, 8'h5A, 0);
      chk("ft stall d", 32'(m_data_w[2]), 32'h5A);
      step(0, 0, 0, 8'h00, 0);
      chk("ft stored c", 32'(count_w[2]), 32'd1);
      chk("ft stored d", 32'(m_data_w[2]), 32'h5A);
      step(0, 0, 0, 8'h00, 0);
      chk("ft held d", 32'(m_data_w[2]), 32'h5A);
      step(0, 0, 0, 8'h00, 1);
      chk("ft pop v", 32'(m_valid_w[2]), 32'd1);
      step(0, 0, 0, 8'h00, 1);
      chk("ft drained c", 32'(count_w[2]), 32'd0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00, 1);

      // Reset in the middle of traffic
      step(0, 0, 1, 8'hC1, 0);
      step(0, 0, 1, 8'hC2, 0);
      step(1, 0, 1, 8'hC3, 1);
      chk("midrst m_valid", 32'(m_valid_w[1]), 32'd0);
      step(0, 0, 0, 8'h00, 1);
      chk("midrst count", 32'(count_w[1]), 32'd0);
      chk("midrst m_valid after", 32'(m_valid_w[1]), 32'd0);

      // Patterned mixed traffic, model-checked every cycle
      for (int i = 0; i < 48; i++) begin
         step(0, (i == 30), (i % 3) != 0, 8'(i + 8'h40), (i % 4) != 1);
      end
      for (int i = 0; i < 6; i++) step(0, 0, 0, 8'h00, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_stage_fifo.md
# pipe_stage_fifo

Parametrised elastic pipeline-stage buffer for inter-stage buses (e.g. M->W). It carries one flat payload vector between an upstream valid/ready producer and a downstream valid/ready consumer. It provides DEPTH entries of buffering, full one-transfer-per-cycle throughput, a selectable fall-through mode and a synchronous flush. Stage wrappers concatenate their per-field signals into `s_data` and split `m_data` back out.

## Interface
Parameters:
- WIDTH, 32, payload width in bits (>=1)
- DEPTH, 2, number of storage entries; power of two, >=2
- FLOW, 0, 0 = registered output (1-cycle latency), 1 = fall-through when empty (0-cycle latency)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous discard of all buffered entries
- s_valid  in  1  upstream payload valid
- s_ready  out  1  buffer can accept
- s_data  in  WIDTH  upstream payload
- m_valid  out  1  payload available downstream
- m_ready  in  1  downstream accepts
- m_data  out  WIDTH  downstream payload
- count  out  $clog2(DEPTH)+1  stored entries, 0..DEPTH

## Operation
- Storage: circular array of DEPTH entries. Read and write pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0. `count` is a separate registered counter.
- Push = s_valid & s_ready. Pop = m_valid & m_ready.
- s_ready = !rst & !flush & (count != DEPTH). It never depends combinationally on m_ready. When full, a push is refused even if a pop happens in the same cycle.
- FLOW=0:
  - m_valid = !rst & !flush & (count != 0)
  - m_data = entry[rd_ptr]
- FLOW=1, count != 0: same as FLOW=0.
- FLOW=1, count == 0:
  - m_valid = s_valid & !rst & !flush; m_data = s_data.
  - If m_ready, the beat bypasses storage. Pointers and count are unchanged.
  - If !m_ready, the beat is written (a normal push).
- Pointer/count update per edge (not flushing):
  - push only (not bypassed): entry[wr_ptr] <= s_data, wr_ptr+1, count+1
  - pop only: rd_ptr+1, count-1
  - push and pop: both pointers advance, count unchanged
- Flush has priority over push/pop. At the edge with flush=1, rd_ptr, wr_ptr and count are cleared to 0, and any concurrent s_valid beat is discarded. Entry contents are left as-is.
- Stability: while m_valid & !m_ready, m_data and m_valid hold until pop or flush. In FLOW=1 with an empty buffer, this relies on upstream holding s_data/s_valid stable, which upstream is required to do.
- Overflow and underflow are impossible by construction. The bench asserts count never exceeds DEPTH and never wraps below 0.

## Timing
- Reset: at the edge with rst=1, pointers=0, count=0 and all entries=0. While rst is high, s_ready=0 and m_valid=0. From the first cycle after rst falls: s_ready=1, m_valid=0, m_data=0, count=0.
- Reset mid-operation discards all contents exactly like flush. No beat is presented after reset that was accepted before it.
- FLOW=0 latency: a beat pushed at edge N is visible on m_valid/m_data in cycle N+1.
- FLOW=1 latency: 0 cycles when empty, same cycle.
- Throughput: 1 beat/cycle sustained for DEPTH>=2 with m_ready held high. No bubbles at steady state.
- count changes only at clock edges. Its value reflects stored entries only; bypassed beats are never counted.

## Test plan
- Reset/idle, FLOW=0, DEPTH=2: hold rst 2 cycles then release -> s_ready=0, m_valid=0 during reset. First cycle after: s_ready=1, m_valid=0, count=0, m_data=0.
- Stream, FLOW=0, DEPTH=2, m_ready=1: push 0x11,0x22,0x33 on consecutive cycles -> m_data 0x11,0x22,0x33 on the following three cycles, count stays 1, no bubble.
- Backpressure/full, DEPTH=4, m_ready=0: push 0xA0..0xA5 with s_valid held -> beats 0xA0..0xA3 accepted, count=4, s_ready=0, 0xA4 held. Raise m_ready -> 0xA0..0xA5 delivered in order, pointers wrap correctly.
- Full with simultaneous pop, DEPTH=2: count=2, s_valid=1, m_ready=1 -> pop only, count=1 next cycle. The push is accepted the following cycle.
- Flush, DEPTH=4: 3 entries stored, assert flush with s_valid=1 (0xFF) and m_ready=1 -> during flush cycle m_valid=0, s_ready=0. Next cycle count=0, m_valid=0, 0xFF never appears at output.
- Fall-through, FLOW=1, DEPTH=2:
  - empty, s_valid=1 with 0x5A, m_ready=1 -> m_valid=1, m_data=0x5A same cycle, count stays 0.
  - same beat with m_ready=0 -> stored, count=1 next cycle, 0x5A held stable until m_ready.
